interface_teclado: RTL and testbench

Keypad front-end that drives the press/correct inputs of `sistema_fechadura`. It synchronizes and debounces a raw key line, captures the 4-bit digit, and compares it against the stored 4-digit code at the position reported by the lock's `s` output. It emits `p` as a clean press level and `c` as a verdict that is stable for the whole press. While the lock reports unlocked (`u=1`), the block can also reprogram the stored code.

---
 rtl/fechadura_pkg.sv | 22 ++
 rtl/interface_teclado_if.sv | 35 +++
 rtl/debounce_sync.sv | 103 ++++++++++
 rtl/interface_teclado.sv | 98 +++++++++
 tb/tb_interface_teclado.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fechadura_pkg.sv
// Shared types and constants for the keypad front-end of the lock.
package fechadura_pkg;

    // Debounce FSM states: released, confirming press, pressed, confirming release.
    typedef enum logic [1:0] {
        SOLTO       = 2'd0,
        CONF_PRESS  = 2'd1,
        PRESSIONADO = 2'd2,
        CONF_SOLTA  = 2'd3
    } estado_t;

    localparam int NUM_DIGITOS = 4;

    // Code loaded on reset; nibble [15:12] is digit 0, nibble [3:0] is digit 3.
    localparam logic [15:0] CODIGO_PADRAO = 16'h4952;

    // Only BCD digits take part in comparison or programming.
    function automatic logic digito_valido(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/interface_teclado_if.sv
// Signal bundle between the keypad/lock side and the keypad front-end.
//
// Protocol: there is no valid/ready pair. key_raw is an asynchronous level,
// digit_raw must be held stable while key_raw=1, and s/u/prog are levels from
// the lock. p is a debounced press level and c is a verdict that is valid and
// constant for as long as p=1 (c=0 whenever p=0). prog_done is a one-cycle
// pulse. state_dbg and widx_dbg expose internal state for observation only.
interface interface_teclado_if;
    import fechadura_pkg::*;

    logic       key_raw;
    logic [3:0] digit_raw;
    logic [1:0] s;
    logic       u;
    logic       prog;

    logic       p;
    logic       c;
    logic       prog_mode;
    logic       prog_done;

    estado_t    state_dbg;
    logic [2:0] widx_dbg;

    modport master (
        output key_raw, digit_raw, s, u, prog,
        input  p, c, prog_mode, prog_done, state_dbg, widx_dbg
    );

    modport slave (
        input  key_raw, digit_raw, s, u, prog,
        output p, c, prog_mode, prog_done, state_dbg, widx_dbg
    );

endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchronizer plus debounce FSM for the raw key line.
// confirm_press/confirm_release mark the edges on which a press or a
// release becomes confirmed; they are decoded from registered state only.
module debounce_sync
    import fechadura_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    key_raw,
    output logic    pressed,
    output logic    confirm_press,
    output logic    confirm_release,
    output estado_t state_dbg
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          key_s;
    estado_t       state;
    estado_t       state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;

    // Bring the asynchronous key line into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            key_s <= 1'b0;
        end else begin
            sync1 <= key_raw;
            key_s <= sync1;
        end
    end

    // State and stability counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SOLTO;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic; the counter restarts on every state entry.
    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        confirm_press   = 1'b0;
        confirm_release = 1'b0;
        case (state)
            SOLTO: begin
                if (key_s) begin
                    state_nx = CONF_PRESS;
                    cnt_nx   = '0;
                end
            end
            CONF_PRESS: begin
                if (!key_s) begin
                    state_nx = SOLTO;
                    cnt_nx   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nx      = PRESSIONADO;
                    cnt_nx        = '0;
                    confirm_press = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            PRESSIONADO: begin
                if (!key_s) begin
                    state_nx = CONF_SOLTA;
                    cnt_nx   = '0;
                end
            end
            CONF_SOLTA: begin
                if (key_s) begin
                    state_nx = PRESSIONADO;
                    cnt_nx   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nx        = SOLTO;
                    cnt_nx          = '0;
                    confirm_release = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = SOLTO;
                cnt_nx   = '0;
            end
        endcase
    end

    assign pressed   = (state == PRESSIONADO) || (state == CONF_SOLTA);
    assign state_dbg = state;

endmodule

// File: rtl/interface_teclado.sv
// Keypad front-end: debounced press level, per-digit verdict against the
// stored code, and code reprogramming while the lock is open.
module interface_teclado
    import fechadura_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [15:0] CODE_RESET      = CODIGO_PADRAO
) (
    input logic               clk,
    input logic               reset,
    interface_teclado_if.slave bus
);

    localparam logic [2:0] WIDX_FIM = 3'(NUM_DIGITOS);

    logic       pressed;
    logic       confirm_press;
    logic       confirm_release;
    estado_t    state;

    logic [3:0] code [NUM_DIGITOS];
    logic [2:0] widx;
    logic       c_q;
    logic       prog_mode;
    logic       prog_done;
    logic       prog_entry;
    logic       write_en;

    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk            (clk),
        .reset          (reset),
        .key_raw        (bus.key_raw),
        .pressed        (pressed),
        .confirm_press  (confirm_press),
        .confirm_release(confirm_release),
        .state_dbg      (state)
    );

    assign prog_entry = bus.prog && bus.u && (state == SOLTO) && !prog_mode;
    // A write needs the lock still open so an abort on the same edge writes nothing.
    assign write_en   = prog_mode && bus.u && confirm_press &&
                        digito_valido(bus.digit_raw) && (widx < WIDX_FIM);

    // Code register file: reset value or programmed digits only.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITOS; i++) begin
                code[i] <= CODE_RESET[(NUM_DIGITOS - 1 - i) * 4 +: 4];
            end
        end else if (write_en) begin
            code[widx[1:0]] <= bus.digit_raw;
        end
    end

    // Verdict is captured once at press confirmation so it holds while s moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_q <= 1'b0;
        end else if (confirm_press) begin
            c_q <= !prog_mode && digito_valido(bus.digit_raw) &&
                   (bus.digit_raw == code[bus.s]);
        end else if (confirm_release) begin
            c_q <= 1'b0;
        end
    end

    // Programming control: entry, digit index, completion pulse and abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            prog_mode <= 1'b0;
            prog_done <= 1'b0;
            widx      <= '0;
        end else begin
            prog_done <= 1'b0;
            if (prog_mode && !bus.u) begin
                prog_mode <= 1'b0;
            end else if (prog_mode && (widx == WIDX_FIM)) begin
                prog_mode <= 1'b0;
                prog_done <= 1'b1;
            end else if (prog_entry) begin
                prog_mode <= 1'b1;
                widx      <= '0;
            end else if (write_en) begin
                widx <= widx + 3'd1;
            end
        end
    end

    assign bus.p         = pressed && !prog_mode;
    assign bus.c         = bus.p && c_q;
    assign bus.prog_mode = prog_mode;
    assign bus.prog_done = prog_done;
    assign bus.state_dbg = state;
    assign bus.widx_dbg  = widx;

endmodule

// File: tb/tb_interface_teclado.sv
// Directed plus randomized bench for the keypad front-end.
module tb_interface_teclado;
    import fechadura_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    interface_teclado_if bus ();

    interface_teclado #(
        .DEBOUNCE_CYCLES(4),
        .CODE_RESET     (16'h4952)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int p_viol = 0;
    int model_code [4];
    int model_widx = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock, then sample just after the edge and track pulse/violation counters.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.prog_done === 1'b1) done_cnt++;
        if (bus.prog_mode === 1'b1 && bus.p !== 1'b0) p_viol++;
    endtask

    task automatic model_reset();
        model_code[0] = 4;
        model_code[1] = 9;
        model_code[2] = 5;
        model_code[3] = 2;
        model_widx = 0;
    endtask

    function automatic logic exp_c(input int sv, input int d);
        return (d <= 9) && (d == model_code[sv]);
    endfunction

    // Normal-mode press: verdict after confirmation, held while s moves, released cleanly.
    task automatic npress(input string tag, input int sv, input int d);
        logic e;
        int   sr;
        e = exp_c(sv, d);
        bus.s = sv[1:0];
        bus.digit_raw = d[3:0];
        bus.key_raw = 1'b1;
        repeat (7) tick();
        check({tag, "_p"}, 32'(bus.p), 32'(1));
        check({tag, "_c"}, 32'(bus.c), 32'(e));
        sr = $urandom_range(0, 3);
        bus.s = sr[1:0];
        repeat (3) tick();
        check({tag, "_c_hold"}, 32'(bus.c), 32'(e));
        bus.key_raw = 1'b0;
        repeat (9) tick();
        check({tag, "_p_rel"}, 32'(bus.p), 32'(0));
    endtask

    // Programming-mode press; the model stores valid digits until four are written.
    task automatic ppress(input string tag, input int d);
        if (d <= 9 && model_widx < 4) begin
            model_code[model_widx] = d;
            model_widx++;
        end
        bus.digit_raw = d[3:0];
        bus.key_raw = 1'b1;
        repeat (7) tick();
        bus.key_raw = 1'b0;
        repeat (9) tick();
        check({tag, "_widx"}, 32'(bus.widx_dbg), 32'(model_widx));
    endtask

    task automatic prog_enter(input string tag);
        bus.u = 1'b1;
        bus.prog = 1'b1;
        tick();
        bus.prog = 1'b0;
        model_widx = 0;
        done_cnt = 0;
        p_viol = 0;
        check({tag, "_enter"}, 32'(bus.prog_mode), 32'(1));
    endtask

    initial begin
        int p_hi;
        int k;
        int n;
        int d;
        bus.key_raw = 1'b0;
        bus.digit_raw = 4'd0;
        bus.s = 2'd0;
        bus.u = 1'b0;
        bus.prog = 1'b0;
        model_reset();

        // Reset state
        repeat (2) tick();
        check("rst_p", 32'(bus.p), 32'(0));
        check("rst_c", 32'(bus.c), 32'(0));
        check("rst_prog_mode", 32'(bus.prog_mode), 32'(0));
        check("rst_prog_done", 32'(bus.prog_done), 32'(0));
        check("rst_state", 32'(bus.state_dbg), 32'(SOLTO));
        check("rst_widx", 32'(bus.widx_dbg), 32'(0));
        reset = 1'b0;
        repeat (2) tick();

        // Test 1: exact press and release latency, correct digit
        bus.s = 2'd0;
        bus.digit_raw = 4'd4;
        bus.key_raw = 1'b1;
        repeat (6) tick();
        check("t1_p_early", 32'(bus.p), 32'(0));
        tick();
        check("t1_p_rise", 32'(bus.p), 32'(1));
        check("t1_c_rise", 32'(bus.c), 32'(1));
        bus.s = 2'd2;
        repeat (5) tick();
        check("t1_c_stable", 32'(bus.c), 32'(1));
        bus.key_raw = 1'b0;
        repeat (6) tick();
        check("t1_p_late", 32'(bus.p), 32'(1));
        tick();
        check("t1_p_fall", 32'(bus.p), 32'(0));
        check("t1_c_fall", 32'(bus.c), 32'(0));
        repeat (3) tick();

        // Test 2: 2-cycle glitch never reaches p
        p_hi = 0;
        bus.key_raw = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) bus.key_raw = 1'b0;
            tick();
            if (bus.p !== 1'b0) p_hi++;
        end
        check("t2_glitch", 32'(p_hi), 32'(0));

        // Test 3: wrong, right and non-BCD digits at position 3
        npress("t3_d1", 3, 1);
        npress("t3_d2", 3, 2);
        npress("t3_d15", 3, 15);

        // prog ignored while locked
        bus.u = 1'b0;
        bus.prog = 1'b1;
        repeat (2) tick();
        bus.prog = 1'b0;
        check("prog_locked", 32'(bus.prog_mode), 32'(0));

        // Test 4: program 1,2,3,4
        prog_enter("t4");
        ppress("t4_1", 1);
        ppress("t4_2", 2);
        ppress("t4_3", 3);
        ppress("t4_4", 4);
        repeat (3) tick();
        check("t4_done_cnt", 32'(done_cnt), 32'(1));
        check("t4_p_quiet", 32'(p_viol), 32'(0));
        check("t4_exit", 32'(bus.prog_mode), 32'(0));
        bus.u = 1'b0;
        npress("t4_s0_d1", 0, 1);
        npress("t4_s0_d4", 0, 4);

        // Test 5: invalid digit while programming is skipped
        prog_enter("t5");
        ppress("t5_12", 12);
        ppress("t5_1", 1);
        ppress("t5_2", 2);
        ppress("t5_3", 3);
        ppress("t5_4", 4);
        repeat (3) tick();
        check("t5_done_cnt", 32'(done_cnt), 32'(1));
        check("t5_p_quiet", 32'(p_viol), 32'(0));
        bus.u = 1'b0;
        npress("t5_s3_d4", 3, 4);

        // Abort: lock closes after two writes; written digits stay, no pulse
        prog_enter("ab");
        ppress("ab_6", 6);
        ppress("ab_7", 7);
        bus.u = 1'b0;
        tick();
        check("ab_exit", 32'(bus.prog_mode), 32'(0));
        repeat (3) tick();
        check("ab_no_done", 32'(done_cnt), 32'(0));
        npress("ab_s0", 0, 6);
        npress("ab_s1", 1, 7);
        npress("ab_s2", 2, 3);

        // Release bounce shorter than the debounce window keeps p high
        bus.s = 2'd3;
        bus.digit_raw = 4'd4;
        bus.key_raw = 1'b1;
        repeat (7) tick();
        k = $urandom_range(1, 3);
        bus.key_raw = 1'b0;
        p_hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == k) bus.key_raw = 1'b1;
            tick();
            if (bus.p !== 1'b1) p_hi++;
        end
        check("bounce_p_low", 32'(p_hi), 32'(0));
        check("bounce_c", 32'(bus.c), 32'(exp_c(3, 4)));
        bus.key_raw = 1'b0;
        repeat (9) tick();

        // Test 6a: reset mid-press drops p on the next edge
        bus.s = 2'd0;
        bus.digit_raw = 4'd6;
        bus.key_raw = 1'b1;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        model_reset();
        check("t6_press_p", 32'(bus.p), 32'(0));
        check("t6_press_c", 32'(bus.c), 32'(0));
        reset = 1'b0;
        bus.key_raw = 1'b0;
        repeat (4) tick();

        // Test 6b: reset after two programming writes restores the default code
        prog_enter("t6");
        ppress("t6_8", 8);
        ppress("t6_9", 9);
        bus.digit_raw = 4'd5;
        bus.key_raw = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        model_reset();
        check("t6_prog_mode", 32'(bus.prog_mode), 32'(0));
        check("t6_p", 32'(bus.p), 32'(0));
        check("t6_widx", 32'(bus.widx_dbg), 32'(0));
        check("t6_state", 32'(bus.state_dbg), 32'(SOLTO));
        reset = 1'b0;
        bus.key_raw = 1'b0;
        bus.u = 1'b0;
        repeat (4) tick();
        npress("t6_s0_d4", 0, 4);

        // Random presses and glitches against the code model
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(1, 3);
                p_hi = 0;
                bus.key_raw = 1'b1;
                for (int j = 0; j < 12; j++) begin
                    if (j == k) bus.key_raw = 1'b0;
                    tick();
                    if (bus.p !== 1'b0) p_hi++;
                end
                check("rnd_glitch", 32'(p_hi), 32'(0));
            end else begin
                k = $urandom_range(0, 3);
                if ($urandom_range(0, 1) == 1) d = model_code[k];
                else d = $urandom_range(0, 15);
                npress("rnd_press", k, d);
            end
        end

        // Random reprogramming including non-BCD digits
        prog_enter("rp");
        n = 0;
        while (model_widx < 4 && n < 12) begin
            ppress("rp_dig", $urandom_range(0, 15));
            n++;
        end
        repeat (3) tick();
        check("rp_done_cnt", 32'(done_cnt), 32'(model_widx == 4 ? 1 : 0));
        check("rp_p_quiet", 32'(p_viol), 32'(0));
        bus.u = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            npress("rp_right", i, model_code[i]);
            npress("rp_other", i, (model_code[i] + 1 + $urandom_range(0, 8)) % 16);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
